mux_nx1_seq: RTL and testbench
==============================

Name: mux_nx1_seq

Overview:
- Parametrised successor to the team's 4:1 4-bit selector: N channels of W bits, with a registered output.
- Two modes:
  - direct mode: handshaked capture of ENT[SEL].
  - scan mode: automatic round-robin stepping through the channels at a programmable interval.
- Sits between the colour/sequence registers and the LED/display drivers. Scan mode plays back stored channels, for example a colour sequence.

Parameters:
- W, 4, data width per channel.
- N, 4, channel count. Must be >= 2; need not be a power of two.
- SEL_W, 2, select width. Must satisfy 2**SEL_W >= N.
- TICK_W, 4, width of the scan-interval field.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- MODE  in  1  0 = direct, 1 = scan. Sampled only in IDLE.
- SEL  in  SEL_W  channel select for direct mode.
- ENT  in  N*W  packed channel inputs. Channel k = ENT[k*W +: W].
- LOAD  in  1  request strobe. Starts a direct capture or a scan run.
- INTERVAL  in  TICK_W  scan dwell time is INTERVAL+1 cycles per channel. Sampled at scan start.
- STOP  in  1  ends a scan run.
- ACK  in  1  consumer accepts OUT.
- OUT  out  W  registered selected data.
- OUT_VALID  out  1  OUT holds a valid sample.
- CUR_SEL  out  SEL_W  channel index currently on OUT.
- BUSY  out  1  high in any state other than IDLE.
- SEL_ERR  out  1  sticky flag: a direct request used SEL >= N. Cleared only by reset.

Behaviour:
- Reset (async assert, sync release):
  - OUT=0, OUT_VALID=0, CUR_SEL=0, BUSY=0, SEL_ERR=0, state IDLE, tick counter 0.
  - Reset mid-operation aborts immediately, with no partial output.
- States: IDLE, HOLD, SCAN.
- IDLE, LOAD=1, MODE=0 (direct):
  - If SEL < N: OUT <= ENT[SEL], CUR_SEL <= SEL, OUT_VALID <= 1, go to HOLD. Latency 1 cycle: OUT is visible the cycle after LOAD.
  - If SEL >= N: OUT <= 0, SEL_ERR <= 1, OUT_VALID stays 0, stay in IDLE.
- HOLD:
  - OUT and CUR_SEL are stable. LOAD is ignored.
  - ACK=1: OUT_VALID <= 0, go to IDLE. OUT keeps its last value.
  - LOAD and ACK in the same cycle: ACK wins. A new LOAD is honoured only from IDLE on a later cycle.
- IDLE, LOAD=1, MODE=1 (scan):
  - Latch INTERVAL.
  - OUT <= ENT[0], CUR_SEL <= 0, OUT_VALID <= 1, tick counter <= 0, go to SCAN.
- SCAN:
  - The tick counter increments every cycle.
  - When the counter equals the latched INTERVAL: counter <= 0, CUR_SEL <= (CUR_SEL == N-1) ? 0 : CUR_SEL+1, OUT <= ENT[next]. This wraps correctly for non-power-of-two N.
  - ENT is sampled only at step boundaries; OUT does not track ENT changes between steps.
  - ACK is ignored in SCAN. OUT_VALID stays 1 throughout.
  - STOP=1: OUT_VALID <= 0, go to IDLE on the next edge. OUT and CUR_SEL keep their values.
  - STOP on the same cycle as a step: the stop wins and no advance happens.
- INTERVAL=0 gives a one-cycle dwell: a new channel every cycle.
- BUSY is combinational from state, equal to (state != IDLE).
- MODE and SEL changes outside IDLE have no effect.

Optional Feature:
- Macro: MUX_NX1_SEQ_PARITY_EN.
- Defined:
  - Adds output port OUT_PAR (1 bit), registered together with OUT, equal to even parity (XOR reduction) of the selected word. Same latency as OUT.
  - Reset value 0.
  - In the SEL_ERR case OUT_PAR is 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, direct capture, hold: W=4, N=4, ENT={3:0xA,2:0x5,1:0xC,0:0x3}.
  - Hold RST_N low mid-run -> all outputs 0.
  - Release; LOAD with MODE=0, SEL=2 -> next cycle OUT=0x5, CUR_SEL=2, OUT_VALID=1, BUSY=1.
  - Change ENT[2] to 0xF with no ACK -> OUT stays 0x5.
  - ACK -> OUT_VALID=0 and BUSY=0 on the next edge.
- Illegal select: N=3, SEL_W=2, LOAD with SEL=3 -> OUT=0, OUT_VALID=0, SEL_ERR=1, stays set after later valid loads.
- Scan with wrap: N=3, INTERVAL=2, LOAD with MODE=1.
  - CUR_SEL sequence 0,1,2,0,1 with each value held exactly 3 cycles.
  - OUT matches ENT[CUR_SEL] at each step.
  - OUT_VALID=1 throughout.
- Scan at minimum interval, then stop: INTERVAL=0 -> CUR_SEL changes every cycle. STOP asserted on a step cycle -> no advance, OUT_VALID=0 and BUSY=0 on the next edge.
- Simultaneous events in HOLD: LOAD and ACK together -> goes to IDLE with no new capture. A LOAD two cycles later captures normally.
- Parity (build with MUX_NX1_SEQ_PARITY_EN): direct-select 0x7 -> OUT_PAR=1; select 0x5 -> OUT_PAR=0.

Source files
------------

// File: rtl/mux_nx1_seq.sv
// N-channel, W-bit registered selector with handshaked direct capture and
// timed round-robin scan. Define MUX_NX1_SEQ_PARITY_EN to add the OUT_PAR output.
module mux_nx1_seq #(
  parameter int W      = 4,
  parameter int N      = 4,
  parameter int SEL_W  = 2,
  parameter int TICK_W = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              MODE,
  input  logic [SEL_W-1:0]  SEL,
  input  logic [N*W-1:0]    ENT,
  input  logic              LOAD,
  input  logic [TICK_W-1:0] INTERVAL,
  input  logic              STOP,
  input  logic              ACK,
  output logic [W-1:0]      OUT,
  output logic              OUT_VALID,
  output logic [SEL_W-1:0]  CUR_SEL,
  output logic              BUSY,
  output logic              SEL_ERR
`ifdef MUX_NX1_SEQ_PARITY_EN
  ,
  output logic              OUT_PAR
`endif
);

  // Handshake: OUT is offered while OUT_VALID=1. In HOLD, ACK=1 consumes it and
  // returns to IDLE (ACK beats a coincident LOAD). In SCAN, ACK is ignored and
  // the run continues until STOP=1.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  localparam logic [SEL_W:0]   N_EXT    = (SEL_W + 1)'(N);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);

  state_t             state;
  state_t             state_nx;
  logic [TICK_W-1:0]  tick_q;
  logic [TICK_W-1:0]  tick_nx;
  logic [TICK_W-1:0]  intv_q;
  logic [TICK_W-1:0]  intv_nx;
  logic [W-1:0]       out_nx;
  logic               valid_nx;
  logic [SEL_W-1:0]   cur_nx;
  logic               err_nx;
`ifdef MUX_NX1_SEQ_PARITY_EN
  logic               par_nx;
`endif

  logic               sel_ok;
  logic               step_due;
  logic [SEL_W-1:0]   next_idx;
  logic [W-1:0]       sel_word;
  logic [W-1:0]       next_word;
  logic [W-1:0]       ch0_word;

  assign sel_ok   = ({1'b0, SEL} < N_EXT);
  assign step_due = (tick_q == intv_q);
  // Explicit wrap so non-power-of-two N never visits an unused index.
  assign next_idx = (CUR_SEL == LAST_IDX) ? '0 : CUR_SEL + SEL_W'(1);
  assign ch0_word = ENT[W-1:0];

  always_comb begin
    sel_word  = '0;
    next_word = '0;
    for (int k = 0; k < N; k++) begin
      if (SEL == SEL_W'(k))      sel_word  = ENT[k*W +: W];
      if (next_idx == SEL_W'(k)) next_word = ENT[k*W +: W];
    end
  end

  always_comb begin
    state_nx = state;
    tick_nx  = tick_q;
    intv_nx  = intv_q;
    out_nx   = OUT;
    valid_nx = OUT_VALID;
    cur_nx   = CUR_SEL;
    err_nx   = SEL_ERR;
`ifdef MUX_NX1_SEQ_PARITY_EN
    par_nx   = OUT_PAR;
`endif
    case (state)
      IDLE: begin
        if (LOAD) begin
          if (MODE) begin
            intv_nx  = INTERVAL;
            tick_nx  = '0;
            out_nx   = ch0_word;
            cur_nx   = '0;
            valid_nx = 1'b1;
            state_nx = SCAN;
`ifdef MUX_NX1_SEQ_PARITY_EN
            par_nx   = ^ch0_word;
`endif
          end else if (sel_ok) begin
            out_nx   = sel_word;
            cur_nx   = SEL;
            valid_nx = 1'b1;
            state_nx = HOLD;
`ifdef MUX_NX1_SEQ_PARITY_EN
            par_nx   = ^sel_word;
`endif
          end else begin
            out_nx   = '0;
            err_nx   = 1'b1;
`ifdef MUX_NX1_SEQ_PARITY_EN
            par_nx   = 1'b0;
`endif
          end
        end
      end
      HOLD: begin
        if (ACK) begin
          valid_nx = 1'b0;
          state_nx = IDLE;
        end
      end
      SCAN: begin
        // STOP takes priority over a step falling on the same cycle.
        if (STOP) begin
          valid_nx = 1'b0;
          state_nx = IDLE;
        end else if (step_due) begin
          tick_nx = '0;
          cur_nx  = next_idx;
          out_nx  = next_word;
`ifdef MUX_NX1_SEQ_PARITY_EN
          par_nx  = ^next_word;
`endif
        end else begin
          tick_nx = tick_q + TICK_W'(1);
        end
      end
      default: begin
        valid_nx = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      tick_q    <= '0;
      intv_q    <= '0;
      OUT       <= '0;
      OUT_VALID <= 1'b0;
      CUR_SEL   <= '0;
      SEL_ERR   <= 1'b0;
`ifdef MUX_NX1_SEQ_PARITY_EN
      OUT_PAR   <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      tick_q    <= tick_nx;
      intv_q    <= intv_nx;
      OUT       <= out_nx;
      OUT_VALID <= valid_nx;
      CUR_SEL   <= cur_nx;
      SEL_ERR   <= err_nx;
`ifdef MUX_NX1_SEQ_PARITY_EN
      OUT_PAR   <= par_nx;
`endif
    end
  end

  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_mux_nx1_seq.sv
// Directed bench for mux_nx1_seq: a 4-channel and a 3-channel instance share
// clock and reset; expected values are hand-computed from the ENT tables.
module tb_mux_nx1_seq;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  // Instance A: N=4, ENT = {3:A, 2:5, 1:C, 0:3}
  logic        a_mode, a_load, a_stop, a_ack;
  logic [1:0]  a_sel;
  logic [15:0] a_ent;
  logic [3:0]  a_intv;
  logic [3:0]  a_out;
  logic        a_valid, a_busy, a_err;
  logic [1:0]  a_cur;
  // Instance B: N=3, ENT = {2:7, 1:5, 0:9}
  logic        b_mode, b_load, b_stop, b_ack;
  logic [1:0]  b_sel;
  logic [11:0] b_ent;
  logic [3:0]  b_intv;
  logic [3:0]  b_out;
  logic        b_valid, b_busy, b_err;
  logic [1:0]  b_cur;
`ifdef MUX_NX1_SEQ_PARITY_EN
  logic        a_par, b_par;
`endif

  mux_nx1_seq #(.W(4), .N(4), .SEL_W(2), .TICK_W(4)) u_a (
    .CLK(CLK), .RST_N(RST_N), .MODE(a_mode), .SEL(a_sel), .ENT(a_ent),
    .LOAD(a_load), .INTERVAL(a_intv), .STOP(a_stop), .ACK(a_ack),
    .OUT(a_out), .OUT_VALID(a_valid), .CUR_SEL(a_cur), .BUSY(a_busy),
    .SEL_ERR(a_err)
`ifdef MUX_NX1_SEQ_PARITY_EN
    , .OUT_PAR(a_par)
`endif
  );

  mux_nx1_seq #(.W(4), .N(3), .SEL_W(2), .TICK_W(4)) u_b (
    .CLK(CLK), .RST_N(RST_N), .MODE(b_mode), .SEL(b_sel), .ENT(b_ent),
    .LOAD(b_load), .INTERVAL(b_intv), .STOP(b_stop), .ACK(b_ack),
    .OUT(b_out), .OUT_VALID(b_valid), .CUR_SEL(b_cur), .BUSY(b_busy),
    .SEL_ERR(b_err)
`ifdef MUX_NX1_SEQ_PARITY_EN
    , .OUT_PAR(b_par)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  int          exp_sel_b [15] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 0, 0, 1, 1, 1};
  logic [3:0]  word_b    [3]  = '{4'h9, 4'h5, 4'h7};
  int          exp_sel_a [6]  = '{0, 1, 2, 3, 0, 1};
  logic [3:0]  word_a    [4]  = '{4'h3, 4'hC, 4'h5, 4'hA};

  initial begin
    RST_N  = 1'b0;
    a_mode = 0; a_load = 0; a_stop = 0; a_ack = 0; a_sel = 0; a_intv = 0;
    a_ent  = 16'hA5C3;
    b_mode = 0; b_load = 0; b_stop = 0; b_ack = 0; b_sel = 0; b_intv = 0;
    b_ent  = 12'h759;

    // Reset state
    step(); step();
    check("rst_out", a_out, 0);
    check("rst_valid", a_valid, 0);
    check("rst_cur", a_cur, 0);
    check("rst_busy", a_busy, 0);
    check("rst_err", a_err, 0);
    RST_N = 1'b1;

    // Start a scan, then assert reset asynchronously mid-run
    a_mode = 1; a_intv = 4'd1; a_load = 1;
    step();
    a_load = 0;
    check("pre_rst_valid", a_valid, 1);
    check("pre_rst_out", a_out, 4'h3);
    step(); step();
    check("pre_rst_cur", a_cur, 1);
    #3 RST_N = 1'b0;
    #1;
    check("mid_rst_out", a_out, 0);
    check("mid_rst_valid", a_valid, 0);
    check("mid_rst_cur", a_cur, 0);
    check("mid_rst_busy", a_busy, 0);
    @(posedge CLK);
    #1 RST_N = 1'b1;

    // Direct capture of channel 2, hold against ENT changes, then ACK
    a_mode = 0; a_sel = 2; a_load = 1;
    step();
    a_load = 0;
    check("dir_out", a_out, 4'h5);
    check("dir_cur", a_cur, 2);
    check("dir_valid", a_valid, 1);
    check("dir_busy", a_busy, 1);
`ifdef MUX_NX1_SEQ_PARITY_EN
    check("dir_par5", a_par, 0);
`endif
    a_ent = 16'hAFC3;
    a_sel = 0;
    step();
    check("hold_out", a_out, 4'h5);
    check("hold_valid", a_valid, 1);
    step();
    check("hold_cur", a_cur, 2);
    a_ack = 1;
    step();
    a_ack = 0;
    check("ack_valid", a_valid, 0);
    check("ack_busy", a_busy, 0);
    check("ack_out_kept", a_out, 4'h5);

    // LOAD and ACK together in HOLD: ACK wins, no new capture
    a_ent = 16'hA5C3;
    a_sel = 1; a_load = 1;
    step();
    check("la_cap_out", a_out, 4'hC);
    a_sel = 3; a_ack = 1;
    step();
    a_load = 0; a_ack = 0;
    check("la_valid", a_valid, 0);
    check("la_busy", a_busy, 0);
    check("la_out", a_out, 4'hC);
    check("la_cur", a_cur, 1);
    step();
    check("la_idle_busy", a_busy, 0);
    a_load = 1;
    step();
    a_load = 0;
    check("la_new_out", a_out, 4'hA);
    check("la_new_cur", a_cur, 3);
    check("la_new_valid", a_valid, 1);
    a_ack = 1;
    step();
    a_ack = 0;

    // Illegal select on N=3 instance; SEL_ERR is sticky
    b_mode = 0; b_sel = 2; b_load = 1;
    step();
    b_load = 0; b_ack = 1;
    check("b_dir_out", b_out, 4'h7);
`ifdef MUX_NX1_SEQ_PARITY_EN
    check("b_par7", b_par, 1);
`endif
    step();
    b_ack = 0;
    b_sel = 3; b_load = 1;
    step();
    b_load = 0;
    check("ill_out", b_out, 0);
    check("ill_valid", b_valid, 0);
    check("ill_err", b_err, 1);
    check("ill_busy", b_busy, 0);
`ifdef MUX_NX1_SEQ_PARITY_EN
    check("ill_par", b_par, 0);
`endif
    b_sel = 1; b_load = 1;
    step();
    b_load = 0;
    check("ill_later_out", b_out, 4'h5);
    check("ill_later_valid", b_valid, 1);
    check("ill_sticky", b_err, 1);
`ifdef MUX_NX1_SEQ_PARITY_EN
    check("b_par5", b_par, 0);
`endif
    b_ack = 1;
    step();
    b_ack = 0;

    // Scan with wrap on N=3, INTERVAL=2; ACK held high must be ignored
    b_mode = 1; b_intv = 4'd2; b_load = 1;
    for (int i = 0; i < 15; i++) begin
      step();
      b_load = 0;
      b_ack  = 1;
      b_mode = 0;
      check($sformatf("scan_cur[%0d]", i), b_cur, exp_sel_b[i]);
      check($sformatf("scan_out[%0d]", i), b_out, word_b[exp_sel_b[i]]);
      check($sformatf("scan_valid[%0d]", i), b_valid, 1);
    end
    // Last sample is a step cycle: STOP must win
    b_stop = 1;
    step();
    b_stop = 0; b_ack = 0;
    check("stop_cur", b_cur, 1);
    check("stop_out", b_out, 4'h5);
    check("stop_valid", b_valid, 0);
    check("stop_busy", b_busy, 0);

    // Minimum interval on N=4: new channel every cycle, then STOP
    a_mode = 1; a_intv = 4'd0; a_load = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      a_load = 0;
      check($sformatf("fast_cur[%0d]", i), a_cur, exp_sel_a[i]);
      check($sformatf("fast_out[%0d]", i), a_out, word_a[exp_sel_a[i]]);
    end
    a_stop = 1;
    step();
    a_stop = 0;
    check("fast_stop_cur", a_cur, 1);
    check("fast_stop_out", a_out, 4'hC);
    check("fast_stop_valid", a_valid, 0);
    check("fast_stop_busy", a_busy, 0);
    step();
    check("fast_idle_cur", a_cur, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
